seq_div4: RTL and testbench
===========================

SEQ_DIV4 -- requirements
Module: seq_div4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; reset is asynchronous and active-low.
REQ-002 Clk  input  1  rising-edge system clock.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 A  input  4  unsigned dividend.
REQ-006 B  input  4  unsigned divisor.
REQ-007 Q  output  4  quotient, registered.
REQ-008 R  output  4  remainder, registered.
REQ-009 Busy  output  1  high while iterating (state CALC).
REQ-010 Done  output  1  one-cycle completion pulse (state DONE).
REQ-011 DivZero  output  1  registered flag: last operation had B==0.

Function
REQ-012 States SHALL be IDLE, CALC and DONE; Busy = (state==CALC); Done = (state==DONE); both are decoded from registered state only.
REQ-013 IDLE with Start=1 at edge k SHALL latch A into the dividend shift register and B into the divisor register, clear the 5-bit partial remainder P, and set the step counter to 3.
REQ-014 At edge k, B!=0 SHALL move IDLE->CALC; B==0 SHALL move IDLE->DONE with Q=4'hF, R=A, DivZero=1.
REQ-015 Each CALC edge SHALL perform one restoring step: P' = {P[3:0], dividend MSB}; dividend shifts left by 1; T = P' + {1'b0,~B} + 1 (5-bit, carry-in 1); carry-out 1 (no borrow) -> P=T[3:0], quotient bit 1; else P=P'[3:0], quotient bit 0; quotient bits shift in at the LSB.
REQ-016 CALC SHALL last exactly 4 edges (k+1..k+4); counter decrements each edge; the edge with counter==0 SHALL move CALC->DONE and load Q/R from the working registers, DivZero=0.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-018 Normal latency: Start edge k -> Done high in the cycle after edge k+4; divide-by-zero: Done high in the cycle after edge k.
REQ-019 Q, R and DivZero SHALL change only on entry to DONE and hold their values until the next DONE entry.
REQ-020 Start SHALL be ignored in CALC and DONE; A and B SHALL be ignored except at the load edge, and changes during CALC SHALL not affect the result.
REQ-021 Arithmetic SHALL be unsigned: A = Q*B + R with R < B for B!=0; A<B gives Q=0, R=A.
REQ-022 Back-to-back operation: Start held high SHALL be accepted on the first IDLE edge after DONE, giving one operation per 6 cycles.

Reset
REQ-023 Rst_n=0 SHALL, asynchronously and without a clock, force state IDLE and clear Q, R, DivZero, the working registers and the counter; Busy=0 and Done=0.
REQ-024 Reset asserted in CALC or DONE SHALL abort the operation with no Done pulse; after release, the first Start SHALL produce a correct result.
REQ-025 Release of Rst_n SHALL take effect at the next rising edge; Start at that edge SHALL be accepted.

Verification
REQ-026 A=13, B=4, Start one cycle -> Busy for 4 cycles, Done after edge k+4, Q=3, R=1, DivZero=0.
REQ-027 A=15, B=1 -> Q=15, R=0; then A=3, B=9 -> Q=0, R=3.
REQ-028 A=7, B=0 -> Done in the cycle after the Start edge, Busy never high, Q=4'hF, R=7, DivZero=1; next op 8/2 -> Q=4, R=0, DivZero=0.
REQ-029 Start pulsed and A/B changed during CALC of 9/2 -> Start ignored, result Q=4, R=1; Start held high -> Done pulses every 6 cycles.
REQ-030 Rst_n low at the second CALC edge of 14/3 -> immediately IDLE, all outputs 0, no Done; after release, 14/3 -> Q=4, R=2.
REQ-031 Exhaustive A,B in 0..15 SHALL match the REQ-021 reference model (B==0 per REQ-014) with exact Done timing.

Source files
------------

// File: rtl/seq_div4_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div4_if
//  Description : Request/result bundle for the 4-bit sequential divider.
//                The master drives start/a/b and observes the result; the
//                slave (the divider) samples the request and drives results.
//  Signals     : start    - operation request, honoured only while idle
//                a        - 4-bit unsigned dividend
//                b        - 4-bit unsigned divisor
//                q        - 4-bit registered quotient
//                r        - 4-bit registered remainder
//                busy     - high while the divider iterates
//                done     - one-cycle completion pulse
//                div_zero - last completed operation had b == 0
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_div4_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       div_zero;

  modport master (
    output start, a, b,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_div4.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div4
//  Description : 4-bit unsigned restoring divider. A request accepted while
//                idle iterates for four cycles (one quotient bit per cycle)
//                and then presents quotient/remainder together with a
//                one-cycle done pulse. A zero divisor skips iteration and
//                completes immediately with q = 4'hF, r = a, div_zero = 1.
//  Ports       : clk   - rising-edge system clock
//                rst_n - asynchronous active-low reset
//                bus   - seq_div4_if slave modport (start/a/b in,
//                        q/r/busy/done/div_zero out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_div4 (
  input  logic        clk,
  input  logic        rst_n,
  seq_div4_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and working registers
  // --------------------------------------------------------------------------
  state_t     state_q,    state_d;
  logic [3:0] dvd_q,      dvd_d;       // dividend shift register
  logic [3:0] dvs_q,      dvs_d;       // divisor
  logic [4:0] p_q,        p_d;         // partial remainder
  logic [3:0] quo_q,      quo_d;       // quotient being assembled
  logic [1:0] cnt_q,      cnt_d;       // remaining steps after this one
  logic [3:0] q_q,        q_d;         // published quotient
  logic [3:0] r_q,        r_d;         // published remainder
  logic       dz_q,       dz_d;        // published divide-by-zero flag

  // --------------------------------------------------------------------------
  // One restoring step (combinational, used only in CALC)
  // --------------------------------------------------------------------------
  logic [4:0] p_shift;
  logic [4:0] trial;
  logic       no_borrow;
  logic [4:0] p_step;
  logic [3:0] quo_step;

  always_comb begin
    p_shift  = {p_q[3:0], dvd_q[3]};
    // p_shift + (16 - divisor). Because p_shift < 2*divisor, the sum lies in
    // [16,31] exactly when p_shift >= divisor, so bit 4 is the no-borrow
    // indication and bits 3:0 hold the difference.
    trial     = p_shift + {1'b0, ~dvs_q} + 5'd1;
    no_borrow = trial[4];
    p_step    = no_borrow ? {1'b0, trial[3:0]} : {1'b0, p_shift[3:0]};
    quo_step  = {quo_q[2:0], no_borrow};
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvd_d = bus.a;
          dvs_d = bus.b;
          p_d   = 5'd0;
          quo_d = 4'd0;
          cnt_d = 2'd3;
          if (bus.b == 4'd0) begin
            // Division by zero completes without iterating.
            state_d = ST_DONE;
            q_d     = 4'hF;
            r_d     = bus.a;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        dvd_d = {dvd_q[2:0], 1'b0};
        p_d   = p_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          // Last step: publish the freshly computed bit and remainder.
          state_d = ST_DONE;
          q_d     = quo_step;
          r_d     = p_step[3:0];
          dz_d    = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= 4'd0;
      dvs_q   <= 4'd0;
      p_q     <= 5'd0;
      quo_q   <= 4'd0;
      cnt_q   <= 2'd0;
      q_q     <= 4'd0;
      r_q     <= 4'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: status is decoded from the registered state only
  // --------------------------------------------------------------------------
  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = (state_q == ST_CALC);
  assign bus.done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_div4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_div4
//  Description : Self-checking bench for seq_div4. Expected results come
//                from plain integer division; expected timing comes from the
//                fixed protocol latencies (4 busy cycles, or none for b == 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div4;

  logic clk;
  logic rst_n;

  seq_div4_if bus ();

  seq_div4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Last published result as the reference sees it.
  logic [3:0] exp_q;
  logic [3:0] exp_r;
  logic       exp_dz;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_q_hold"},  {4'd0, bus.q},        {4'd0, exp_q});
    chk({tag, "_r_hold"},  {4'd0, bus.r},        {4'd0, exp_r});
    chk({tag, "_dz_hold"}, {7'd0, bus.div_zero}, {7'd0, exp_dz});
  endtask

  // Issue one operation and check its whole timeline. Called one time unit
  // after a rising edge (or from mid-cycle) with the divider idle; returns
  // one time unit after the edge that brings it back to idle.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input bit junk);
    logic [3:0] rq;
    logic [3:0] rr;
    if (tbv == 4'd0) begin
      rq = 4'hF;
      rr = ta;
    end else begin
      rq = ta / tbv;
      rr = ta % tbv;
    end

    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
    @(posedge clk); #1;
    bus.start = 1'b0;

    if (tbv != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        chk("calc_busy", {7'd0, bus.busy}, 8'd1);
        chk("calc_done", {7'd0, bus.done}, 8'd0);
        chk_held("calc");
        if (junk) begin
          bus.a     = 4'($urandom);
          bus.b     = 4'($urandom);
          bus.start = 1'($urandom);
        end
        @(posedge clk); #1;
      end
    end

    exp_q  = rq;
    exp_r  = rr;
    exp_dz = (tbv == 4'd0);
    chk("done_busy", {7'd0, bus.busy},     8'd0);
    chk("done_pulse", {7'd0, bus.done},    8'd1);
    chk("res_q",     {4'd0, bus.q},        {4'd0, exp_q});
    chk("res_r",     {4'd0, bus.r},        {4'd0, exp_r});
    chk("res_dz",    {7'd0, bus.div_zero}, {7'd0, exp_dz});

    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", {7'd0, bus.done}, 8'd0);
    chk("idle_busy", {7'd0, bus.busy}, 8'd0);
    chk_held("idle");
  endtask

  initial begin
    int done_cnt;
    int gap;
    n_cmp     = 0;
    n_err     = 0;
    exp_q     = 4'd0;
    exp_r     = 4'd0;
    exp_dz    = 1'b0;
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.b     = 4'd0;

    // Reset state, checked before any clock edge has arrived.
    rst_n = 1'b0;
    #3;
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_done", {7'd0, bus.done}, 8'd0);
    chk_held("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(4'd13, 4'd4, 1'b0);
    run_op(4'd15, 4'd1, 1'b0);
    run_op(4'd3,  4'd9, 1'b0);
    run_op(4'd7,  4'd0, 1'b0);
    run_op(4'd8,  4'd2, 1'b0);
    run_op(4'd9,  4'd2, 1'b1);

    // Start held high: one completion every 6 cycles.
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 4'd2;
    done_cnt  = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        chk("b2b_cycle", 8'(c), 8'(4 + 6 * done_cnt));
        chk("b2b_q", {4'd0, bus.q}, 8'd4);
        chk("b2b_r", {4'd0, bus.r}, 8'd1);
        done_cnt++;
      end
    end
    chk("b2b_count", 8'(done_cnt), 8'd5);
    bus.start = 1'b0;
    exp_q  = 4'd4;
    exp_r  = 4'd1;
    exp_dz = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of 14/3: abort without a done pulse.
    bus.start = 1'b1;
    bus.a     = 4'd14;
    bus.b     = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_q  = 4'd0;
    exp_r  = 4'd0;
    exp_dz = 1'b0;
    chk("abort_busy", {7'd0, bus.busy}, 8'd0);
    chk("abort_done", {7'd0, bus.done}, 8'd0);
    chk_held("abort");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", {7'd0, bus.done}, 8'd0);
    end
    // Release mid-cycle; the start presented at the next edge is accepted.
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd14, 4'd3, 1'b0);

    // Exhaustive sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(4'(ia), 4'(ib), 1'b0);
      end
    end

    // Random operations with input noise during CALC and random idle gaps.
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("gap_idle", {7'd0, bus.busy | bus.done}, 8'd0);
      end
      run_op(4'($urandom), 4'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
